// File: rtl/spexp_result_merge16.sv
// Re-merges the exp and softplus result streams of the shared activation unit into issue order.
// Optional head-of-line watchdog enabled by defining SPEXP_MERGE_WDOG_EN.
module spexp_result_merge16 #(
  parameter int DW       = 16,
  parameter int DEPTH    = 8,
  parameter int WDOG_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid_i,
  input  logic                   issue_mode_i,
  output logic                   issue_ready_o,
  input  logic                   exp_valid_i,
  input  logic [DW-1:0]          exp_data_i,
  input  logic                   sp_valid_i,
  input  logic [DW-1:0]          sp_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic [DW-1:0]          m_data_o,
  output logic                   m_mode_o,
  output logic [$clog2(DEPTH):0] outstanding_o,
  output logic [2:0]             err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic            order_mem [DEPTH];
  logic [PW-1:0]   order_wr, order_rd;
  logic [DW-1:0]   exp_mem [DEPTH];
  logic [PW-1:0]   exp_wr, exp_rd;
  logic [DW-1:0]   sp_mem [DEPTH];
  logic [PW-1:0]   sp_wr, sp_rd;

  logic [PW-1:0]   pend_exp, pend_sp;
  logic [PW-1:0]   outstanding;
  logic [1:0]      err_q;
  logic            wdog_err;

  logic            order_empty;
  logic            exp_empty, exp_full, sp_empty, sp_full;
  logic            issue_accept;
  logic            exp_hit, exp_unexp, exp_push, exp_ovf;
  logic            sp_hit, sp_unexp, sp_push, sp_ovf;
  logic            head_mode, match, load, handshake;
  logic            pop_exp, pop_sp;
  logic            inc_exp, inc_sp;
  logic [DW-1:0]   exp_head, sp_head;

  assign order_empty = (order_wr == order_rd);
  assign exp_empty   = (exp_wr == exp_rd);
  assign sp_empty    = (sp_wr == sp_rd);
  assign exp_full    = (exp_wr[AW] != exp_rd[AW]) && (exp_wr[AW-1:0] == exp_rd[AW-1:0]);
  assign sp_full     = (sp_wr[AW] != sp_rd[AW]) && (sp_wr[AW-1:0] == sp_rd[AW-1:0]);

  // Credit covers tokens still in the order FIFO and the one parked in the output register.
  assign issue_ready_o = (outstanding < DEPTH_P);
  assign issue_accept  = issue_valid_i && issue_ready_o;
  assign inc_exp       = issue_accept && !issue_mode_i;
  assign inc_sp        = issue_accept && issue_mode_i;

  assign exp_hit   = exp_valid_i && (pend_exp != '0);
  assign exp_unexp = exp_valid_i && (pend_exp == '0);
  assign exp_push  = exp_hit && !exp_full;
  assign exp_ovf   = exp_hit && exp_full;
  assign sp_hit    = sp_valid_i && (pend_sp != '0);
  assign sp_unexp  = sp_valid_i && (pend_sp == '0);
  assign sp_push   = sp_hit && !sp_full;
  assign sp_ovf    = sp_hit && sp_full;

  assign head_mode = order_mem[order_rd[AW-1:0]];
  assign exp_head  = exp_mem[exp_rd[AW-1:0]];
  assign sp_head   = sp_mem[sp_rd[AW-1:0]];
  assign match     = !order_empty && (head_mode ? !sp_empty : !exp_empty);
  assign load      = match && (!m_valid_o || m_ready_i);
  assign pop_exp   = load && !head_mode;
  assign pop_sp    = load && head_mode;
  assign handshake = m_valid_o && m_ready_i;

  // Storage arrays need no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (issue_accept) order_mem[order_wr[AW-1:0]] <= issue_mode_i;
    if (exp_push)     exp_mem[exp_wr[AW-1:0]]     <= exp_data_i;
    if (sp_push)      sp_mem[sp_wr[AW-1:0]]       <= sp_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      order_wr <= '0;
      order_rd <= '0;
      exp_wr   <= '0;
      exp_rd   <= '0;
      sp_wr    <= '0;
      sp_rd    <= '0;
    end else begin
      if (issue_accept) order_wr <= order_wr + 1'b1;
      if (load)         order_rd <= order_rd + 1'b1;
      if (exp_push)     exp_wr   <= exp_wr + 1'b1;
      if (pop_exp)      exp_rd   <= exp_rd + 1'b1;
      if (sp_push)      sp_wr    <= sp_wr + 1'b1;
      if (pop_sp)       sp_rd    <= sp_rd + 1'b1;
    end
  end

  // A strobe is consumed against its pending count even if the FIFO had to drop it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_exp <= '0;
      pend_sp  <= '0;
    end else begin
      if (inc_exp && !exp_hit)      pend_exp <= pend_exp + 1'b1;
      else if (!inc_exp && exp_hit) pend_exp <= pend_exp - 1'b1;
      if (inc_sp && !sp_hit)        pend_sp  <= pend_sp + 1'b1;
      else if (!inc_sp && sp_hit)   pend_sp  <= pend_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({issue_accept, handshake})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_mode_o  <= 1'b0;
    end else if (load) begin
      m_valid_o <= 1'b1;
      m_data_o  <= head_mode ? sp_head : exp_head;
      m_mode_o  <= head_mode;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      if (exp_ovf || sp_ovf)     err_q[0] <= 1'b1;
      if (exp_unexp || sp_unexp) err_q[1] <= 1'b1;
    end
  end

`ifdef SPEXP_MERGE_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_CYC);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYC - 1);

  logic [WW-1:0] wdog_cnt;
  logic          wdog_flag;

  // The count only advances while the head token has no result to pair with; a stalled
  // but matched head merely holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt  <= '0;
      wdog_flag <= 1'b0;
    end else if (load || order_empty) begin
      wdog_cnt <= '0;
    end else if (!match) begin
      if (wdog_cnt != WDOG_MAX) wdog_cnt <= wdog_cnt + 1'b1;
      if (wdog_cnt == WDOG_LAST) wdog_flag <= 1'b1;
    end
  end

  assign wdog_err = wdog_flag;
`else
  assign wdog_err = 1'b0;
`endif

  assign outstanding_o = outstanding;
  assign err_o         = {wdog_err, err_q};

endmodule

// File: tb/tb_spexp_result_merge16.sv
// Self-checking bench for spexp_result_merge16: vector table, scoreboard monitor and corner-case sequences.
module tb_spexp_result_merge16;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_mode = 1'b0;
  logic          issue_ready;
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          sp_valid = 1'b0;
  logic [DW-1:0] sp_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_mode;
  logic [3:0]    outstanding;
  logic [2:0]    err;

  spexp_result_merge16 #(.DW(DW), .DEPTH(DEPTH), .WDOG_CYC(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid_i (issue_valid),
    .issue_mode_i  (issue_mode),
    .issue_ready_o (issue_ready),
    .exp_valid_i   (exp_valid),
    .exp_data_i    (exp_data),
    .sp_valid_i    (sp_valid),
    .sp_data_i     (sp_data),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .m_data_o      (m_data),
    .m_mode_o      (m_mode),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          mode;
    logic [DW-1:0] data;
  } sb_rec_t;

  typedef struct {
    logic          mode;
    logic [DW-1:0] data;
    int            gap;
    logic [DW-1:0] exp_out;
    logic          exp_mode;
  } vec_t;

  sb_rec_t sb[$];
  sb_rec_t mon_rec;
  vec_t    vecs[5];
  int      checks = 0;
  int      errors = 0;
  logic [DW-1:0] held;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one token; the scoreboard learns the value its result will carry.
  task automatic applyStimulus(input logic mode, input logic [DW-1:0] data);
    if (issue_ready) begin
      sb_rec_t r;
      r.mode = mode;
      r.data = data;
      sb.push_back(r);
    end
    issue_valid = 1'b1;
    issue_mode  = mode;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic sendResult(input logic mode, input logic [DW-1:0] data);
    if (mode) begin
      sp_valid = 1'b1;
      sp_data  = data;
    end else begin
      exp_valid = 1'b1;
      exp_data  = data;
    end
    step();
    sp_valid  = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  // Handshakes complete at the next rising edge; compare against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_extra: got %0h expected no output", m_data);
      end else begin
        mon_rec = sb.pop_front();
        checkOutput("sb_data", 32'(m_data), 32'(mon_rec.data));
        checkOutput("sb_mode", 32'(m_mode), 32'(mon_rec.mode));
      end
    end
  end

  initial begin
    vecs[0] = '{mode: 1'b0, data: 16'h402E, gap: 17, exp_out: 16'h402E, exp_mode: 1'b0};
    vecs[1] = '{mode: 1'b1, data: 16'h3C00, gap: 0,  exp_out: 16'h3C00, exp_mode: 1'b1};
    vecs[2] = '{mode: 1'b0, data: 16'hFFFF, gap: 3,  exp_out: 16'hFFFF, exp_mode: 1'b0};
    vecs[3] = '{mode: 1'b1, data: 16'h0001, gap: 1,  exp_out: 16'h0001, exp_mode: 1'b1};
    vecs[4] = '{mode: 1'b0, data: 16'h8000, gap: 0,  exp_out: 16'h8000, exp_mode: 1'b0};

    doReset();
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_m_data", 32'(m_data), 32'd0);
    checkOutput("rst_m_mode", 32'(m_mode), 32'd0);
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_issue_ready", 32'(issue_ready), 32'd1);

    // Single tokens: two-edge latency from result strobe to m_valid, then handshake.
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].data);
      checkOutput("vec_outstanding_issue", 32'(outstanding), 32'd1);
      repeat (vecs[i].gap) step();
      sendResult(vecs[i].mode, vecs[i].data);
      checkOutput("vec_valid_early", 32'(m_valid), 32'd0);
      step();
      checkOutput("vec_valid", 32'(m_valid), 32'd1);
      checkOutput("vec_data", 32'(m_data), 32'(vecs[i].exp_out));
      checkOutput("vec_mode", 32'(m_mode), 32'(vecs[i].exp_mode));
      step();
      checkOutput("vec_outstanding_done", 32'(outstanding), 32'd0);
      checkOutput("vec_err", 32'(err), 32'd0);
    end

    // Reorder: softplus results arrive first but must wait for the exp head.
    applyStimulus(1'b0, 16'h3E98);
    applyStimulus(1'b1, 16'h398C);
    applyStimulus(1'b0, 16'h3053);
    applyStimulus(1'b1, 16'h3A0D);
    sendResult(1'b1, 16'h398C);
    sendResult(1'b1, 16'h3A0D);
    step();
    checkOutput("reorder_hold", 32'(m_valid), 32'd0);
    sendResult(1'b0, 16'h3E98);
    sendResult(1'b0, 16'h3053);
    for (int t = 0; t < 40 && sb.size() != 0; t++) step();
    checkOutput("reorder_drain", 32'(sb.size()), 32'd0);
    step();
    checkOutput("reorder_outstanding", 32'(outstanding), 32'd0);
    checkOutput("reorder_err", 32'(err), 32'd0);

    // Credit exhaustion and backpressure.
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 16'h1000 + 16'(i));
    checkOutput("credit_ready", 32'(issue_ready), 32'd0);
    checkOutput("credit_outstanding", 32'(outstanding), 32'd8);
    issue_valid = 1'b1;
    issue_mode  = 1'b1;
    step();
    issue_valid = 1'b0;
    checkOutput("credit_ignored", 32'(outstanding), 32'd8);
    for (int i = 0; i < DEPTH; i++) sendResult(1'b0, 16'h1000 + 16'(i));
    step();
    held = m_data;
    checkOutput("bp_first", 32'(m_data), 32'h1000);
    for (int t = 0; t < 10; t++) begin
      step();
      checkOutput("bp_stable", 32'(m_data), 32'(held));
      checkOutput("bp_valid", 32'(m_valid), 32'd1);
    end
    m_ready = 1'b1;
    step();
    checkOutput("credit_return", 32'(issue_ready), 32'd1);
    checkOutput("credit_out_7", 32'(outstanding), 32'd7);
    repeat (7) step();
    checkOutput("bp_burst_drain", 32'(sb.size()), 32'd0);
    checkOutput("bp_burst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("bp_err", 32'(err), 32'd0);

    // Unexpected result, cleared by reset.
    sendResult(1'b1, 16'h1234);
    checkOutput("unexp_err", 32'(err), 32'b010);
    step();
    checkOutput("unexp_no_out", 32'(m_valid), 32'd0);
    doReset();
    checkOutput("unexp_cleared", 32'(err), 32'd0);

    // Reset mid-flight drops pending tokens; a late result becomes unexpected.
    applyStimulus(1'b0, 16'h5555);
    applyStimulus(1'b1, 16'h6666);
    doReset();
    checkOutput("midrst_outstanding", 32'(outstanding), 32'd0);
    sendResult(1'b0, 16'h5555);
    step();
    checkOutput("midrst_err", 32'(err), 32'b010);
    checkOutput("midrst_no_out", 32'(m_valid), 32'd0);
    doReset();

    // Watchdog: softplus head with no result.
    applyStimulus(1'b1, 16'h7777);
    repeat (70) step();
`ifdef SPEXP_MERGE_WDOG_EN
    checkOutput("wdog_err", 32'(err), 32'b100);
`else
    checkOutput("wdog_err", 32'(err), 32'b000);
`endif
    checkOutput("wdog_no_out", 32'(m_valid), 32'd0);
    doReset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
